// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic lane: op-field width and op encodings.
// Imported by the gate array, the pipeline wrapper, the ALU top and the bench.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT_A = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT_B = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd6;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational WIDTH-bit gate array: op, a, b -> result.
// Kept free of state so the ALU top can reuse it outside the pipeline.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND:   o_result = i_a & i_b;
      OP_OR:    o_result = i_a | i_b;
      OP_NOT_A: o_result = ~i_a;
      OP_NOT_B: o_result = ~i_b;
      OP_NAND:  o_result = ~(i_a & i_b);
      OP_NOR:   o_result = ~(i_a | i_b);
      OP_XOR:   o_result = i_a ^ i_b;
      OP_XNOR:  o_result = ~(i_a ^ i_b);
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic lane: S1 holds operands, S2 holds result and flags.
// Sustains one beat per cycle; in_ready depends combinationally on out_ready.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] result_count
);

  logic             r_s1_full;
  logic [OP_W-1:0]  r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_full;
  logic [WIDTH-1:0] r_s2_data;
  logic             r_s2_zero;
  logic             r_s2_parity;
  logic [CNT_W-1:0] r_count;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic             w_deliver;
  logic [WIDTH-1:0] w_result;

  assign w_s2_adv  = !r_s2_full || out_ready;
  assign w_s1_adv  = r_s1_full && w_s2_adv;
  assign in_ready  = !r_s1_full || w_s1_adv;
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = r_s2_full && out_ready;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (r_s1_op),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .o_result (w_result)
  );

  // Whenever S1 can move (in_ready), its next occupancy is simply whether a beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_full <= 1'b0;
      r_s1_op   <= '0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
    end else begin
      if (in_ready) r_s1_full <= w_accept;
      if (w_accept) begin
        r_s1_op <= in_op;
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
      end
    end
  end

  // Result registers only load on a real beat, so an emptied S2 keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_full   <= 1'b0;
      r_s2_data   <= '0;
      r_s2_zero   <= 1'b1;
      r_s2_parity <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_full <= r_s1_full;
      if (r_s1_full) begin
        r_s2_data   <= w_result;
        r_s2_zero   <= ~|w_result;
        r_s2_parity <= ^w_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_deliver) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign out_valid    = r_s2_full;
  assign out_data     = r_s2_data;
  assign out_zero     = r_s2_zero;
  assign out_parity   = r_s2_parity;
  assign result_count = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: drivers push expected results on accept, monitors pop on deliver.
// dut8 (WIDTH=8, CNT_W=4) takes the directed tests, dut13 (WIDTH=13) the random soak.
`timescale 1ns/1ps
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  typedef struct {
    logic [31:0] data;
    bit          zero;
    bit          par;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v8 = 0, r8, ord8 = 0, ov8, z8, p8;
  logic [2:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, d8;
  logic [3:0]  c8;

  logic        v13 = 0, r13, ord13 = 0, ov13, z13, p13;
  logic [2:0]  op13 = 0;
  logic [12:0] a13 = 0, b13 = 0, d13;
  logic [15:0] c13;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_op(op8),
    .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(ord8), .out_data(d8),
    .out_zero(z8), .out_parity(p8), .result_count(c8));

  logic_unit_pipe #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(v13), .in_ready(r13), .in_op(op13),
    .in_a(a13), .in_b(b13), .out_valid(ov13), .out_ready(ord13), .out_data(d13),
    .out_zero(z13), .out_parity(p13), .result_count(c13));

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit mon8_en = 0, mon13_en = 0, flush8 = 0, chk_lat = 0;
  exp_t q8[$];
  exp_t q13[$];
  int del13 = 0;

  always @(negedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: each op is a 2-input truth table, indexed per bit by {a_bit, b_bit}.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    logic [3:0] tt [8];
    logic [31:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0101;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b0110; tt[7] = 4'b1001;
    r = 0;
    for (int i = 0; i < w; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input int c);
    exp_t e;
    int ones = 0;
    for (int i = 0; i < 32; i++) ones += int'(d[i]);
    e.data = d; e.zero = (d == 0); e.par = ones[0]; e.cyc = c;
    return e;
  endfunction

  task automatic cyc8(input bit v, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input bit ordy, output bit acc);
    @(negedge clk);
    v8 = v; op8 = op; a8 = a; b8 = b; ord8 = ordy;
    #1;
    acc = v && r8;
    if (acc) q8.push_back(mk(model(op, 32'(a), 32'(b), 8), cyc));
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit ordy);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 50) begin
      cyc8(1'b1, op, a, b, ordy, acc);
      n++;
    end
    if (!acc) chk("send8_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle8(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) cyc8(1'b0, 3'd0, 8'h00, 8'h00, ordy, acc);
  endtask

  // Monitor for dut8: counter tracking, stall stability, in-order scoreboard.
  logic [3:0] exp_cnt8 = 0;
  bit stall8 = 0;
  logic [9:0] prev8 = 0;
  always begin
    exp_t e;
    @(negedge clk); #2;
    if (flush8) begin
      q8.delete(); exp_cnt8 = 0; stall8 = 0; flush8 = 0;
    end
    if (mon8_en) begin
      chk("cnt8", 32'(c8), 32'(exp_cnt8));
      if (stall8) chk("hold8", 32'({d8, z8, p8}), 32'(prev8));
      if (ov8 && ord8) begin
        if (q8.size() == 0) chk("unexpected8", 32'(d8), 32'hDEAD);
        else begin
          e = q8.pop_front();
          chk("data8", 32'(d8), e.data);
          chk("zero8", 32'(z8), 32'(e.zero));
          chk("par8", 32'(p8), 32'(e.par));
          if (chk_lat) chk("latency8", 32'(cyc - e.cyc), 32'd2);
          exp_cnt8 = exp_cnt8 + 4'd1;
        end
      end
      stall8 = ov8 && !ord8;
      prev8 = {d8, z8, p8};
    end
  end

  logic [15:0] exp_cnt13 = 0;
  bit stall13 = 0;
  logic [14:0] prev13 = 0;
  always begin
    exp_t e;
    @(negedge clk); #2;
    if (mon13_en) begin
      chk("cnt13", 32'(c13), 32'(exp_cnt13));
      if (stall13) chk("hold13", 32'({d13, z13, p13}), 32'(prev13));
      if (ov13 && ord13) begin
        if (q13.size() == 0) chk("unexpected13", 32'(d13), 32'hDEAD);
        else begin
          e = q13.pop_front();
          chk("data13", 32'(d13), e.data);
          chk("zero13", 32'(z13), 32'(e.zero));
          chk("par13", 32'(p13), 32'(e.par));
          exp_cnt13 = exp_cnt13 + 16'd1;
          del13++;
        end
      end
      stall13 = ov13 && !ord13;
      prev13 = {d13, z13, p13};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    bit acc;
    logic [7:0] sweep_exp [8];
    sweep_exp[0] = 8'hC0; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'h0F; sweep_exp[3] = 8'h33;
    sweep_exp[4] = 8'h3F; sweep_exp[5] = 8'h03; sweep_exp[6] = 8'h3C; sweep_exp[7] = 8'hC3;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ov8", 32'(ov8), 0);
    chk("rst_d8", 32'(d8), 0);
    chk("rst_z8", 32'(z8), 1);
    chk("rst_p8", 32'(p8), 0);
    chk("rst_c8", 32'(c8), 0);
    chk("rst_ov13", 32'(ov13), 0);
    chk("rst_c13", 32'(c13), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(r8), 1);
    mon8_en = 1;

    // Truth sweep: model must reproduce the documented result list.
    for (int i = 0; i < 8; i++)
      chk("model_sweep", model(3'(i), 32'hF0, 32'hCC, 8), 32'(sweep_exp[i]));
    chk_lat = 1;
    for (int i = 0; i < 8; i++) send8(3'(i), 8'hF0, 8'hCC, 1'b1);
    idle8(3, 1'b1);
    chk_lat = 0;
    chk("sweep_cnt", 32'(c8), 8);

    send8(OP_AND, 8'hF0, 8'h0F, 1'b1);
    send8(OP_OR, 8'h07, 8'h00, 1'b1);
    idle8(3, 1'b1);

    // Back-pressure: two beats fill the pipe, the third must stall until out_ready.
    send8(OP_XOR, 8'h5A, 8'h0F, 1'b0);
    send8(OP_NAND, 8'hAA, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc8(1'b1, OP_NOR, 8'h12, 8'h34, 1'b0, acc);
      chk("bp_stall", 32'(acc), 0);
    end
    send8(OP_NOR, 8'h12, 8'h34, 1'b1);
    idle8(4, 1'b1);
    chk("bp_cnt", 32'(c8), 13);

    // Reset mid-flight: short pulse after the monitor has sampled this cycle.
    send8(OP_OR, 8'h81, 8'h00, 1'b0);
    send8(OP_XNOR, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    v8 = 0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_ov8", 32'(ov8), 0);
    chk("midrst_d8", 32'(d8), 0);
    chk("midrst_c8", 32'(c8), 0);
    flush8 = 1;
    rst_n = 1'b1;
    idle8(5, 1'b1);
    chk("midrst_gone", 32'(c8), 0);

    // Counter wrap with CNT_W=4: monitor checks 15, 0, 1 as they pass.
    for (int i = 0; i < 17; i++)
      send8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1);
    idle8(3, 1'b1);
    chk("wrap_final", 32'(c8), 1);

    // Random soak on the 13-bit instance.
    mon13_en = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      v13 = 1'($urandom); op13 = 3'($urandom); a13 = 13'($urandom); b13 = 13'($urandom);
      ord13 = 1'($urandom);
      #1;
      if (v13 && r13) q13.push_back(mk(model(op13, 32'(a13), 32'(b13), 13), cyc));
    end
    @(negedge clk);
    v13 = 0; ord13 = 1;
    repeat (5) @(negedge clk);
    #3;
    chk("soak_drained", 32'(q13.size()), 0);
    chk("soak_cnt", 32'(c13), 32'(del13));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Pipelined, parametrised successor to the two-input gate block. It applies one of eight bitwise logic operations (AND, OR, NOT_A, NOT_B, NAND, NOR, XOR, XNOR) to WIDTH-bit operands and returns the result with zero and parity flags. A valid/ready handshake runs on both sides, and the block sustains one operation per cycle under back-pressure. It is the logic lane of the ALU, sitting beside the arithmetic datapath and feeding the shared result mux.

## Interface
- WIDTH, default 8: operand and result width in bits (≥1).
- CNT_W, default 16: width of the delivered-result counter.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_op  input  3  operation select (encoding below)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0
- out_parity  output  1  XOR-reduction of out_data
- result_count  output  CNT_W  results delivered since reset

## Operation
- Op encoding: 0 AND, 1 OR, 2 NOT_A (~a), 3 NOT_B (~b), 4 NAND, 5 NOR, 6 XOR, 7 XNOR. The ops are bitwise across all WIDTH bits.
- Stage 1 (S1): registers op, a and b. s1_full is set on accept.
- Stage 2 (S2): registers the computed result, zero and parity. s2_full drives out_valid.
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- S2 advances when !s2_full || out_ready.
- S1 advances when s1_full && (S2 advances).
- in_ready = !s1_full || (S1 advances). This is a combinational path from out_ready. It is permitted and documented.
- result_count increments by 1 on each deliver. It wraps from 2^CNT_W−1 to 0.
- Back-pressure: while out_valid && !out_ready, out_data, out_zero and out_parity hold stable. The producer may keep in_valid high; nothing is dropped.
- Full pipeline (both stages full) with out_ready low: in_ready = 0.
- Full pipeline with out_ready high: deliver, shift and accept all happen in the same cycle. Throughput stays at 1/cycle.
- Empty pipeline: out_valid = 0. out_data holds its last value; consumers ignore it.
- in_op, in_a and in_b are sampled only on accept. Changes at other times have no effect.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - s1_full and s2_full to 0,
  - out_valid to 0,
  - out_data to 0, out_zero to 1, out_parity to 0,
  - result_count to 0.
- in_ready is 1 in the first cycle after reset release.
- Reset mid-operation: in-flight beats are discarded, not delivered, and not counted.
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+1. Its data is registered at edge k+1, so it is visible in the cycle between edges k+1 and k+2.
- Back-to-back accepts with out_ready held at 1 give one result per cycle.
- With out_ready low, the pipeline holds two beats. The third beat is stalled (in_ready = 0) until a deliver.
- Simultaneous deliver and accept with S1 empty: S2 loads the next result if S1 held one; otherwise out_valid falls.

## Structure
- Shared package logic_unit_pkg holds the op localparams OP_AND…OP_XNOR and the op-field width of 3. The testbench and the ALU top include it.
- Sub-module logic_unit_core: a purely combinational, WIDTH-parameterised gate array (op, a, b → result). It is instantiated between S1 and S2 and is reusable by the ALU top.
- logic_unit_pipe contains only the stage registers, the handshake logic and the counter.

## Test plan
- Full truth sweep, WIDTH=8, a=0xF0, b=0xCC, ops 0..7 back-to-back with out_ready=1 → results C0, FC, 0F, 33, 3F, 03, 3C, C3 in order, one per cycle after 2-cycle latency; result_count ends at 8.
- Flags: AND with a=0xF0, b=0x0F → out_data 0x00, zero=1, parity=0. OR with a=0x07, b=0x00 → 0x07, zero=0, parity=1.
- Back-pressure: out_ready=0, push 3 beats → in_ready drops after 2 accepts and out_data is stable. Raise out_ready → all 3 results are delivered in order with no loss or duplication.
- Counter wrap: CNT_W=4, deliver 17 results → result_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
- Reset mid-flight: 2 beats in the pipeline, pulse rst_n low for a partial cycle → immediately out_valid=0, out_data=0, result_count=0, and neither beat ever appears.
- Random soak: random in_valid/out_ready, WIDTH=13 → every delivered result matches the reference model, in order, and the count equals the number of delivers.
